// File: rtl/lc3b_types.sv
// Shared LC-3b types: set index, cache tag, cache controller states and
// the mux-select encodings used by the cache datapath.
package lc3b_types;

  typedef logic [2:0] lc3b_set;
  typedef logic [8:0] lc3b_c_tag;

  localparam int unsigned LC3B_C_OFFSET_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  localparam logic DATA_SEL_CPU      = 1'b0;
  localparam logic DATA_SEL_PMEM     = 1'b1;
  localparam logic PMEM_ADDR_CPU     = 1'b0;
  localparam logic PMEM_ADDR_STORED  = 1'b1;

endpackage

// File: rtl/cache_perf_counter.sv
// Saturating event counter; holds at all-ones, clears on synchronous reset.
module cache_perf_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the LC-3b direct-mapped write-back L1 cache.
// Optional performance counters are built when CACHE_PERF_CNT_EN is defined.
//
// state     | meaning
// IDLE      | serve hits; on a miss pick writeback or allocate
// WRITEBACK | write the dirty victim line back to pmem
// ALLOCATE  | fetch the requested line from pmem and install it
module cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  output logic mem_resp,
  input  logic hit,
  input  logic dirty,
  output logic load_data,
  output logic load_tag,
  output logic load_valid,
  output logic load_dirty,
  output logic dirty_in,
  output logic data_sel,
  output logic pmem_addr_sel,
  output logic pmem_read,
  output logic pmem_write,
  input  logic pmem_resp
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
`endif
);

  cache_state_t state_q, state_d;
  logic         req;

  // A simultaneous read and write is treated as a write.
  assign req = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_resp      = 1'b0;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    load_valid    = 1'b0;
    load_dirty    = 1'b0;
    dirty_in      = 1'b0;
    data_sel      = DATA_SEL_CPU;
    pmem_addr_sel = PMEM_ADDR_CPU;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            if (mem_write) begin
              load_data  = 1'b1;
              data_sel   = DATA_SEL_CPU;
              load_dirty = 1'b1;
              dirty_in   = 1'b1;
            end
          end else begin
            state_d = dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = PMEM_ADDR_STORED;
        if (pmem_resp) begin
          state_d = ALLOCATE;
        end
      end

      ALLOCATE: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = PMEM_ADDR_CPU;
        if (pmem_resp) begin
          load_data  = 1'b1;
          data_sel   = DATA_SEL_PMEM;
          load_tag   = 1'b1;
          load_valid = 1'b1;
          load_dirty = 1'b1;
          dirty_in   = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  // The completing hit after a fill belongs to the miss, not the hit count.
  logic after_alloc_q;
  logic hit_inc, miss_inc, wb_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      after_alloc_q <= 1'b0;
    end else begin
      after_alloc_q <= (state_q == ALLOCATE);
    end
  end

  assign hit_inc  = (state_q == IDLE) && mem_resp && !after_alloc_q;
  assign miss_inc = (state_q == IDLE) && (state_d != IDLE);
  assign wb_inc   = (state_q == WRITEBACK) && pmem_resp;

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk(clk), .reset(reset), .inc(hit_inc), .count(hit_count)
  );
  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .reset(reset), .inc(miss_inc), .count(miss_count)
  );
  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk(clk), .reset(reset), .inc(wb_inc), .count(wb_count)
  );
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed self-checking bench for cache_control; exercises the counter
// block as well when CACHE_PERF_CNT_EN is defined.
module tb_cache_control;
  import lc3b_types::*;

  localparam int CW = 2;

  // Output vector order:
  // {mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in,
  //  data_sel, pmem_addr_sel, pmem_read, pmem_write}
  localparam logic [9:0] O_NONE      = 10'b0000000000;
  localparam logic [9:0] O_RD_HIT    = 10'b1000000000;
  localparam logic [9:0] O_WR_HIT    = 10'b1100110000;
  localparam logic [9:0] O_ALLOC     = 10'b0000000010;
  localparam logic [9:0] O_FILL      = 10'b0111101010;
  localparam logic [9:0] O_WB        = 10'b0000000101;

  logic clk = 1'b0;
  logic reset, mem_read, mem_write, hit, dirty, pmem_resp;
  logic mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in;
  logic data_sel, pmem_addr_sel, pmem_read, pmem_write;
`ifdef CACHE_PERF_CNT_EN
  logic [CW-1:0] hit_count, miss_count, wb_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit(hit), .dirty(dirty),
    .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .dirty_in(dirty_in), .data_sel(data_sel),
    .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  function automatic logic [9:0] outs();
    return {mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in,
            data_sel, pmem_addr_sel, pmem_read, pmem_write};
  endfunction

  // Apply inputs mid-cycle and let combinational outputs settle.
  task automatic drive(input logic rst, input logic rd, input logic wr,
                       input logic h, input logic d, input logic pr);
    @(negedge clk);
    reset = rst; mem_read = rd; mem_write = wr;
    hit = h; dirty = d; pmem_resp = pr;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      n_checks++;
      if (outs() !== O_NONE) begin
        n_fail++;
        $display("FAIL reset_outs cyc%0d got=%b exp=%b", i, outs(), O_NONE);
      end
    end
    drive(0, 1, 0, 0, 0, 0);
    n_checks++;
    if (outs() !== O_NONE) begin
      n_fail++; $display("FAIL post_reset_idle got=%b exp=%b", outs(), O_NONE);
    end
    drive(0, 1, 0, 0, 0, 0);
    n_checks++;
    if (outs() !== O_ALLOC) begin
      n_fail++; $display("FAIL post_reset_alloc got=%b exp=%b", outs(), O_ALLOC);
    end
    drive(0, 1, 0, 0, 0, 1);
    n_checks++;
    if (outs() !== O_FILL) begin
      n_fail++; $display("FAIL post_reset_fill got=%b exp=%b", outs(), O_FILL);
    end
    drive(0, 1, 0, 1, 0, 0);
    n_checks++;
    if (outs() !== O_RD_HIT) begin
      n_fail++; $display("FAIL post_reset_hit got=%b exp=%b", outs(), O_RD_HIT);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_read_hit();
    drive(0, 1, 0, 1, 0, 0);
    n_checks++;
    if (outs() !== O_RD_HIT) begin
      n_fail++; $display("FAIL read_hit got=%b exp=%b", outs(), O_RD_HIT);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut.state_q !== IDLE || outs() !== O_NONE) begin
      n_fail++;
      $display("FAIL read_hit_stay state=%0d outs=%b exp state=0 outs=%b",
               dut.state_q, outs(), O_NONE);
    end
  endtask

  task automatic test_clean_write_miss();
    int rd_cycles = 0;
    drive(0, 0, 1, 0, 0, 0);
    n_checks++;
    if (outs() !== O_NONE) begin
      n_fail++; $display("FAIL cwm_idle got=%b exp=%b", outs(), O_NONE);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 0, 0, (i == 4));
      if (pmem_read) rd_cycles++;
      n_checks++;
      if (outs() !== ((i == 4) ? O_FILL : O_ALLOC)) begin
        n_fail++;
        $display("FAIL cwm_alloc cyc%0d got=%b exp=%b", i, outs(),
                 (i == 4) ? O_FILL : O_ALLOC);
      end
    end
    n_checks++;
    if (rd_cycles != 4) begin
      n_fail++; $display("FAIL cwm_pmem_read_len got=%0d exp=4", rd_cycles);
    end
    drive(0, 0, 1, 1, 0, 0);
    n_checks++;
    if (outs() !== O_WR_HIT) begin
      n_fail++; $display("FAIL cwm_write_hit got=%b exp=%b", outs(), O_WR_HIT);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_dirty_read_miss();
    int overlap = 0;
    drive(0, 1, 0, 0, 1, 0);
    n_checks++;
    if (outs() !== O_NONE) begin
      n_fail++; $display("FAIL drm_idle got=%b exp=%b", outs(), O_NONE);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 0, 0, 1, (i == 3));
      if (pmem_read && pmem_write) overlap++;
      n_checks++;
      if (outs() !== O_WB) begin
        n_fail++; $display("FAIL drm_wb cyc%0d got=%b exp=%b", i, outs(), O_WB);
      end
    end
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 0, 0, 1, (i == 5));
      if (pmem_read && pmem_write) overlap++;
      n_checks++;
      if (outs() !== ((i == 5) ? O_FILL : O_ALLOC)) begin
        n_fail++;
        $display("FAIL drm_alloc cyc%0d got=%b exp=%b", i, outs(),
                 (i == 5) ? O_FILL : O_ALLOC);
      end
    end
    drive(0, 1, 0, 1, 0, 0);
    n_checks++;
    if (outs() !== O_RD_HIT) begin
      n_fail++; $display("FAIL drm_resp got=%b exp=%b", outs(), O_RD_HIT);
    end
    n_checks++;
    if (overlap != 0) begin
      n_fail++; $display("FAIL drm_overlap got=%0d exp=0", overlap);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_alloc();
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    n_checks++;
    if (outs() !== O_ALLOC) begin
      n_fail++; $display("FAIL rma_alloc1 got=%b exp=%b", outs(), O_ALLOC);
    end
    drive(1, 1, 0, 0, 0, 0);
    n_checks++;
    if (outs() !== O_ALLOC) begin
      n_fail++; $display("FAIL rma_alloc2 got=%b exp=%b", outs(), O_ALLOC);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut.state_q !== IDLE || outs() !== O_NONE) begin
      n_fail++;
      $display("FAIL rma_after state=%0d outs=%b exp state=0 outs=%b",
               dut.state_q, outs(), O_NONE);
    end
  endtask

  task automatic test_edge_cases();
    // pmem_resp in IDLE is ignored
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut.state_q !== IDLE || outs() !== O_NONE) begin
      n_fail++;
      $display("FAIL idle_resp state=%0d outs=%b exp state=0 outs=%b",
               dut.state_q, outs(), O_NONE);
    end
    // read+write together acts as a write
    drive(0, 1, 1, 1, 0, 0);
    n_checks++;
    if (outs() !== O_WR_HIT) begin
      n_fail++; $display("FAIL rd_wr_both got=%b exp=%b", outs(), O_WR_HIT);
    end
    // pmem_resp already high on the first ALLOCATE cycle
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    n_checks++;
    if (outs() !== O_FILL) begin
      n_fail++; $display("FAIL first_cyc_resp got=%b exp=%b", outs(), O_FILL);
    end
    drive(0, 1, 0, 1, 0, 0);
    n_checks++;
    if (outs() !== O_RD_HIT) begin
      n_fail++; $display("FAIL first_cyc_hit got=%b exp=%b", outs(), O_RD_HIT);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

`ifdef CACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (hit_count !== 2'd0 || miss_count !== 2'd0 || wb_count !== 2'd0) begin
      n_fail++;
      $display("FAIL perf_clear got=%0d/%0d/%0d exp=0/0/0",
               hit_count, miss_count, wb_count);
    end
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (hit_count !== 2'd3) begin
      n_fail++; $display("FAIL perf_hit_sat got=%0d exp=3", hit_count);
    end
    drive(0, 1, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 1, 1);
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (miss_count !== 2'd1 || wb_count !== 2'd1) begin
      n_fail++;
      $display("FAIL perf_miss_wb got=%0d/%0d exp=1/1", miss_count, wb_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    hit = 1'b0; dirty = 1'b0; pmem_resp = 1'b0;
    test_reset();
    test_read_hit();
    test_clean_write_miss();
    test_dirty_read_miss();
    test_reset_mid_alloc();
    test_edge_cases();
`ifdef CACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_control.md
# cache_control

Control FSM for the LC-3b direct-mapped, write-back L1 cache: 8 sets, 128-bit lines, one tag/valid/dirty per set. It sequences the cache datapath (data, tag, valid and dirty arrays, which are read combinationally and written on the clock edge) between the CPU memory port and physical memory. It decides hit and miss service, dirty-line writeback and line allocation. It holds no data itself; every array write is issued through the load strobes below.

## Interface
- CNT_WIDTH, 16, width of each performance counter (used only with CACHE_PERF_CNT_EN)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  CPU request complete
- hit  in  1  datapath: indexed line valid and tag match
- dirty  in  1  datapath: indexed line dirty bit
- load_data  out  1  write data array at current index
- load_tag  out  1  write tag array
- load_valid  out  1  set valid bit
- load_dirty  out  1  write dirty bit with dirty_in
- dirty_in  out  1  value for dirty bit
- data_sel  out  1  0 = CPU write merge, 1 = pmem line
- pmem_addr_sel  out  1  0 = {CPU tag, index}, 1 = {stored tag, index}
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_resp  in  1  physical memory done
- hit_count, miss_count, wb_count  out  CNT_WIDTH each  (macro only)

## Operation
- States: IDLE, WRITEBACK, ALLOCATE; reset state IDLE.
- IDLE, no request: all outputs 0.
- IDLE, request and hit:
  - mem_resp=1 in the same cycle.
  - On a write hit, load_data=1, data_sel=0, load_dirty=1, dirty_in=1.
  - Stay in IDLE.
- IDLE, request and miss: dirty=1 goes to WRITEBACK; dirty=0 goes to ALLOCATE. mem_resp=0.
- WRITEBACK:
  - pmem_write=1 and pmem_addr_sel=1, held until pmem_resp.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1 and pmem_addr_sel=0, held until pmem_resp.
  - On pmem_resp: load_data=1, data_sel=1, load_tag=1, load_valid=1, load_dirty=1, dirty_in=0. Go to IDLE.
  - Back in IDLE the request now hits and is serviced as above. A write miss therefore completes as a write hit.
- mem_read and mem_write asserted together is illegal; the controller treats it as a write.
- Request dropped during WRITEBACK/ALLOCATE is a CPU protocol violation. The controller still finishes the memory transaction and returns to IDLE.
- pmem_read and pmem_write are never asserted together.

## Timing
- All outputs except state-registered counters are combinational from state and inputs (Moore for pmem strobes, Mealy for mem_resp and loads).
- Read or write hit latency: 0 cycles (mem_resp in the request cycle).
- Clean miss: ALLOCATE cycles until pmem_resp, plus 1 IDLE cycle.
- Dirty miss: WRITEBACK cycles, plus ALLOCATE cycles, plus 1.
- pmem_resp seen in IDLE is ignored.
- Reset mid-operation: state returns to IDLE at the edge, so pmem strobes deassert in the next cycle. Arrays are not cleared by this block.
- pmem_resp in the first cycle of WRITEBACK/ALLOCATE is legal. The transition occurs at that edge.

## Configuration
- CACHE_PERF_CNT_EN defined:
  - hit_count increments on each IDLE cycle with mem_resp=1 that did not follow an ALLOCATE.
  - miss_count increments on each IDLE→WRITEBACK/ALLOCATE transition.
  - wb_count increments on WRITEBACK exit.
  - All counters saturate at all-ones and clear on reset.
- Undefined: counter ports and logic are absent; FSM behaviour is identical.

## Structure
- lc3b_types package additions:
  - cache_state_t enum (IDLE, WRITEBACK, ALLOCATE).
  - lc3b_c_tag typedef (9-bit tag, offset 4 bits, index uses the existing lc3b_set).
  - Select constants for data_sel and pmem_addr_sel.
- Sub-module cache_perf_counter: one saturating counter, parameter CNT_WIDTH, inputs clk/reset/inc. Instantiated three times under the macro.

## Test plan
- Reset for 2 cycles with mem_read=1 and hit=0 → all outputs 0 during reset; the first cycle after reset moves to ALLOCATE.
- Read hit at index 3 → mem_resp=1 the same cycle, no load strobes, state stays IDLE.
- Write miss, dirty=0, pmem_resp after 4 cycles → pmem_read high for 4 cycles. Fill strobes with dirty_in=0 appear with pmem_resp. The next cycle has hit=1, load_data=1, data_sel=0, dirty_in=1, mem_resp=1.
- Read miss, dirty=1, pmem_resp after 3 cycles then 5 cycles → pmem_write with pmem_addr_sel=1 for 3 cycles, then pmem_read for 5 cycles, then mem_resp. pmem strobes never overlap.
- Reset asserted in the 2nd ALLOCATE cycle → pmem_read=0 the next cycle, state IDLE, no load strobes issued.
- With CACHE_PERF_CNT_EN, CNT_WIDTH=2: 5 hits → hit_count=3 (saturated). One dirty miss → miss_count=1, wb_count=1.
